// File: rtl/mem_in_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_in_reader_if : input-memory read port plus the outgoing byte stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_in_reader_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              mem_cen;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_q;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output mem_cen, mem_wen, mem_a, out_valid, out_data,
      input  mem_q, out_ready
   );

   modport slave (
      input  mem_cen, mem_wen, mem_a, out_valid, out_data,
      output mem_q, out_ready
   );
endinterface
`default_nettype wire

// File: rtl/mem_in_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_in_reader : strided reads from the input memory, emitted as a byte stream
// Optional MEM_IN_RD_STALL_CNT_EN adds stall_cnt.                 Rev 1.0
// ---------------------------------------------------------------------------
module mem_in_reader #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [ADDR_W-1:0] stride,
   output logic              busy,
   output logic              done,
`ifdef MEM_IN_RD_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   mem_in_reader_if.master   bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [LEN_W-1:0]  rem_issue_q, rem_issue_d;
   logic [LEN_W-1:0]  rem_out_q, rem_out_d;
   logic              inflight_q, inflight_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop;
   logic              issue;
   logic [CNT_W:0]    occ;
`ifdef MEM_IN_RD_STALL_CNT_EN
   logic [31:0]       stall_cnt_q, stall_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      stride_d    = stride_q;
      mem_a_d     = mem_a_q;
      rem_issue_d = rem_issue_q;
      rem_out_d   = rem_out_q;
      done_d      = 1'b0;
      fifo_d      = fifo_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;

      pop   = (count_q != '0) && bus.out_ready;
      // Slots already promised (stored + in flight) after this cycle's pop.
      occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
      issue = (state_q == RUN) && (rem_issue_q != '0) && (occ < OCC_MAX);
      inflight_d = issue;

      case (state_q)
         IDLE: begin
            // done_q high means the previous transfer is still retiring.
            if (start && !done_q) begin
               if (length != '0) begin
                  cur_addr_d  = base_addr;
                  stride_d    = stride;
                  rem_issue_d = length;
                  rem_out_d   = length;
                  state_d     = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issue) begin
               mem_a_d     = cur_addr_q;
               cur_addr_d  = cur_addr_q + stride_q;
               rem_issue_d = rem_issue_q - 1'b1;
               if (rem_issue_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         default: ;
      endcase

      if ((state_q != IDLE) && pop) begin
         rem_out_d = rem_out_q - 1'b1;
         if (rem_out_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end

      if (inflight_q) begin
         fifo_d[wr_ptr_q] = bus.mem_q;
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop);

`ifdef MEM_IN_RD_STALL_CNT_EN
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && start && !done_q)
         stall_cnt_d = '0;
      else if ((count_q != '0) && !bus.out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         stride_q    <= '0;
         mem_a_q     <= '0;
         rem_issue_q <= '0;
         rem_out_q   <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         fifo_q      <= '{default: '0};
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         stride_q    <= stride_d;
         mem_a_q     <= mem_a_d;
         rem_issue_q <= rem_issue_d;
         rem_out_q   <= rem_out_d;
         inflight_q  <= inflight_d;
         done_q      <= done_d;
         fifo_q      <= fifo_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

`ifdef MEM_IN_RD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt = stall_cnt_q;
`endif

   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign bus.mem_cen   = ~issue;
   assign bus.mem_wen   = 1'b1;
   assign bus.mem_a     = issue ? cur_addr_q : mem_a_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = fifo_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_mem_in_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_in_reader : directed scoreboard bench for mem_in_reader   Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_in_reader;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  length = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic              busy;
   logic              done;
`ifdef MEM_IN_RD_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   mem_in_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   mem_in_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .stride    (stride),
      .busy      (busy),
      .done      (done),
`ifdef MEM_IN_RD_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   // Memory model: registered read, one-cycle latency, mem[i] = i & 0xFF.
   logic [7:0] mem [0:32767];
   initial for (int i = 0; i < 32768; i++) mem[i] = 8'(i & 255);
   always @(posedge clk) if (!bus_if.mem_cen) bus_if.mem_q <= mem[bus_if.mem_a];

   int tests = 0;
   int fails = 0;
   logic [7:0]        exp_q [$];
   logic [ADDR_W-1:0] exp_a [$];
   int  outstanding = 0;
   int  stall_seen = 0;
   bit  done_due = 1'b0;
   bit  zero_pending = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations on every address issue and stream handshake.
   bit                m_hs, m_iss, m_exp_done;
   logic [ADDR_W-1:0] m_a;
   logic [7:0]        m_d;
   always @(negedge clk) begin
      m_hs  = bus_if.out_valid && bus_if.out_ready;
      m_iss = !bus_if.mem_cen;
      if (!rst_n) begin
         outstanding  = 0;
         done_due     = 1'b0;
         zero_pending = 1'b0;
      end else begin
         m_exp_done = done_due || zero_pending;
         if (done || m_exp_done) chk("done_pulse", 32'(done), 32'(m_exp_done));
         zero_pending = 1'b0;
         if (m_iss) begin
            chk("mem_wen", 32'(bus_if.mem_wen), 32'd1);
            chk("issue_gate", 32'((outstanding - (m_hs ? 1 : 0)) < 2), 32'd1);
            if (exp_a.size() == 0) chk("unexpected_issue", 32'(bus_if.mem_cen), 32'd1);
            else begin
               m_a = exp_a.pop_front();
               chk("mem_a", 32'(bus_if.mem_a), 32'(m_a));
            end
         end
         if (m_hs) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus_if.out_valid), 32'd0);
            else begin
               m_d = exp_q.pop_front();
               chk("out_data", 32'(bus_if.out_data), 32'(m_d));
            end
         end
         if (bus_if.out_valid && !bus_if.out_ready) stall_seen++;
         done_due    = m_hs && (exp_q.size() == 0) && busy;
         outstanding = outstanding + (m_iss ? 1 : 0) - (m_hs ? 1 : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ready(input bit tog, inout int k);
      logic [5:0] pat;
      pat = 6'b101001;   // 1,0,0,1,0,1 from bit 0 upward
      if (tog) begin
         bus_if.out_ready = pat[k % 6];
         k++;
      end else begin
         bus_if.out_ready = 1'b1;
      end
   endtask

   task automatic run_xfer(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] len,
                           input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] addrs [$],
                           input bit tog);
      int k = 0;
      int cyc = 0;
      foreach (addrs[i]) begin
         exp_a.push_back(addrs[i]);
         exp_q.push_back(addrs[i][7:0]);
      end
      stall_seen = 0;
      base_addr = b; length = len; stride = s; start = 1'b1;
      bus_if.out_ready = 1'b1;
      step();
      start = 1'b0;
      drive_ready(tog, k);
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("valid_lat_c1", 32'(bus_if.out_valid), 32'd0);
      step();
      drive_ready(tog, k);
      @(negedge clk);
      chk("valid_lat_c2", 32'(bus_if.out_valid), 32'd0);
      step();
      drive_ready(tog, k);
      @(negedge clk);
      chk("valid_lat_c3", 32'(bus_if.out_valid), 32'd1);
      while ((busy || exp_q.size() != 0) && cyc < 200) begin
         step();
         cyc++;
         drive_ready(tog, k);
         if (tog && cyc == 2) begin
            start = 1'b1; base_addr = 15'h7000; length = 16'd9;
         end else if (tog && cyc == 3) begin
            start = 1'b0;
         end
      end
      chk("xfer_complete", 32'(!busy && exp_q.size() == 0 && exp_a.size() == 0), 32'd1);
      exp_q.delete();
      exp_a.delete();
      bus_if.out_ready = 1'b1;
   endtask

   logic [ADDR_W-1:0] q [$];
   logic [ADDR_W-1:0] a;

   initial begin
      bus_if.out_ready = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_done",      32'(done), 32'd0);
      chk("rst_mem_cen",   32'(bus_if.mem_cen), 32'd1);
      chk("rst_mem_wen",   32'(bus_if.mem_wen), 32'd1);
      chk("rst_mem_a",     32'(bus_if.mem_a), 32'd0);
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus_if.out_data), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (2) step();

      // Sequential read, back-to-back delivery, then a start in the done cycle.
      q = {15'h0010, 15'h0011, 15'h0012, 15'h0013, 15'h0014, 15'h0015, 15'h0016, 15'h0017};
      run_xfer(15'h0010, 16'd8, 15'd1, q, 1'b0);
      chk("done_cycle_seen", 32'(done), 32'd1);
      start = 1'b1; base_addr = 15'h0020; length = 16'd3;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", 32'(busy), 32'd0);

      // Address wrap at the top of memory.
      repeat (2) step();
      q = {15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      run_xfer(15'h7FFE, 16'd4, 15'd1, q, 1'b0);

      // Bank-crossing column stride.
      repeat (2) step();
      q = {15'h0100, 15'h0200, 15'h0300, 15'h0400};
      run_xfer(15'h0100, 16'd4, 15'h0100, q, 1'b0);

      // Backpressure pattern with an ignored start mid-transfer.
      repeat (2) step();
      q = {15'h0040, 15'h0043, 15'h0046, 15'h0049, 15'h004C, 15'h004F};
      run_xfer(15'h0040, 16'd6, 15'd3, q, 1'b1);
`ifdef MEM_IN_RD_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(stall_seen));
`endif

      // Zero-length start.
      repeat (2) step();
      base_addr = 15'h0123; length = 16'd0; stride = 15'd1; start = 1'b1;
      step();
      start = 1'b0;
      zero_pending = 1'b1;
      @(negedge clk);
      chk("zero_busy_c1", 32'(busy), 32'd0);
      chk("zero_cen_c1",  32'(bus_if.mem_cen), 32'd1);
      step();
      @(negedge clk);
      chk("zero_busy_c2", 32'(busy), 32'd0);
      chk("zero_cen_c2",  32'(bus_if.mem_cen), 32'd1);

      // Reset in the third cycle of a 16-byte transfer.
      repeat (2) step();
      for (int i = 0; i < 16; i++) begin
         a = 15'h0200 + 15'(i);
         exp_a.push_back(a);
         exp_q.push_back(a[7:0]);
      end
      base_addr = 15'h0200; length = 16'd16; stride = 15'd1; start = 1'b1;
      bus_if.out_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_q.delete();
      exp_a.delete();
      @(negedge clk);
      chk("midrst_busy",  32'(busy), 32'd0);
      chk("midrst_valid", 32'(bus_if.out_valid), 32'd0);
      chk("midrst_cen",   32'(bus_if.mem_cen), 32'd1);
      chk("midrst_done",  32'(done), 32'd0);
      repeat (2) step();
      q = {15'h0033, 15'h0035};
      run_xfer(15'h0033, 16'd2, 15'd2, q, 1'b0);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1);
   end
endmodule
`default_nettype wire
